// File: rtl/cereal_pkg.sv
// rtl/cereal_pkg.sv - shared state type and frame constants for the cereal transmit arbiter
package cereal_pkg;

   typedef enum logic [1:0] {
      FLUSH = 2'd0,
      IDLE  = 2'd1,
      START = 2'd2,
      WAIT  = 2'd3
   } arb_state_t;

   // Baud pulses the transmitter needs for start bit + 8 data bits + stop bit
   localparam int FRAME_PULSES = 10;
   // One pulse more than a frame, so any frame in flight at reset has drained
   localparam int FLUSH_PULSES = 11;
   localparam int PULSE_CNT_W  = 4;

endpackage

// File: rtl/cereal_baud_gen.sv
// rtl/cereal_baud_gen.sv - free-running baud tick generator, one-cycle pulse every BAUD_DIV clocks
module cereal_baud_gen
   import cereal_pkg::*;
#(
   parameter int BAUD_DIV = 434
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tx_pulse
);

   localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_wrap;

   assign w_wrap     = (r_cnt == CNT_LAST);
   assign o_tx_pulse = w_wrap;

   // divider counts 0..BAUD_DIV-1 regardless of what the arbiter is doing
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (w_wrap) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cereal_tx_arbiter.sv
// rtl/cereal_tx_arbiter.sv - shares one cereal transmitter among N_REQ byte producers; CEREAL_ARB_FIXED_PRIO_EN selects fixed priority
module cereal_tx_arbiter
   import cereal_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int BAUD_DIV = 434
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic [N_REQ-1:0]           i_req_valid,
   input  logic [8*N_REQ-1:0]         i_req_data,
   output logic [N_REQ-1:0]           o_req_ready,
   output logic                       o_tx_pulse,
   output logic [7:0]                 o_tx_data,
   output logic                       o_tx_start,
   output logic                       o_busy,
   output logic [$clog2(N_REQ)-1:0]   o_grant_id
);

   localparam int ID_W = $clog2(N_REQ);
   localparam logic [PULSE_CNT_W-1:0] CNT_FLUSH_LAST = PULSE_CNT_W'(FLUSH_PULSES - 1);
   localparam logic [PULSE_CNT_W-1:0] CNT_FRAME_LAST = PULSE_CNT_W'(FRAME_PULSES - 1);

   arb_state_t             r_state;
   arb_state_t             w_next_state;
   logic [PULSE_CNT_W-1:0] r_cnt;
   logic [7:0]             r_tx_data;
   logic [ID_W-1:0]        r_grant;
   logic [ID_W-1:0]        w_ptr;
   logic [ID_W:0]          w_pick;
   logic                   w_found;
   logic [ID_W-1:0]        w_win_id;
   logic [7:0]             w_win_data;
   logic                   w_pulse;

   // First valid requester at or after 'start', wrapping; MSB flags that one was found
   function automatic logic [ID_W:0] pick_winner(input logic [N_REQ-1:0] valid,
                                                 input logic [ID_W-1:0]  start);
      logic [ID_W:0] res;
      int            idx;
      res = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = (int'(start) + i) % N_REQ;
         if (valid[ID_W'(idx)]) begin
            res = {1'b1, ID_W'(idx)};
         end
      end
      return res;
   endfunction

   cereal_baud_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .o_tx_pulse (w_pulse)
   );

   assign w_pick     = pick_winner(i_req_valid, w_ptr);
   assign w_found    = w_pick[ID_W];
   assign w_win_id   = w_pick[ID_W-1:0];
   assign w_win_data = i_req_data[{w_win_id, 3'b000} +: 8];

   assign o_tx_pulse = w_pulse;
   assign o_tx_data  = r_tx_data;
   assign o_grant_id = r_grant;

`ifdef CEREAL_ARB_FIXED_PRIO_EN
   assign w_ptr = '0;
`else
   logic [ID_W-1:0] r_ptr;

   assign w_ptr = r_ptr;

   // search start moves just past the requester that was served
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= '0;
      end else if (r_state == IDLE && w_found) begin
         r_ptr <= ID_W'((int'(w_win_id) + 1) % N_REQ);
      end
   end
`endif

   // state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= FLUSH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next-state: pulses are counted only in FLUSH and WAIT, never in START
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         FLUSH:   if (w_pulse && r_cnt == CNT_FLUSH_LAST) w_next_state = IDLE;
         IDLE:    if (w_found) w_next_state = START;
         START:   w_next_state = WAIT;
         WAIT:    if (w_pulse && r_cnt == CNT_FRAME_LAST) w_next_state = IDLE;
         default: w_next_state = FLUSH;
      endcase
   end

   // outputs decoded from the current state; ready is a same-cycle grant in IDLE
   always_comb begin
      o_req_ready = '0;
      o_tx_start  = 1'b0;
      o_busy      = 1'b1;
      unique case (r_state)
         IDLE: begin
            o_busy = 1'b0;
            if (w_found) o_req_ready = N_REQ'(1) << w_win_id;
         end
         START:   o_tx_start = 1'b1;
         default: ;
      endcase
   end

   // pulse counter and the byte/grant latched at accept time
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt     <= '0;
         r_tx_data <= 8'h00;
         r_grant   <= '0;
      end else begin
         unique case (r_state)
            FLUSH, WAIT: begin
               if (w_pulse) r_cnt <= (w_next_state == IDLE) ? '0 : r_cnt + 1'b1;
            end
            START: r_cnt <= '0;
            IDLE: begin
               if (w_found) begin
                  r_tx_data <= w_win_data;
                  r_grant   <= w_win_id;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
